// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int num_slices(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// state   | meaning
// IDLE    | waiting for start
// RUN     | processing slices, busy high
// DONE    | one-cycle done pulse, can accept a back-to-back start
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = num_slices(WIDTH, CHUNK);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             c_q, c_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] part_next;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (c_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // New slice enters at the MSB end so the word is aligned after N shifts.
    assign part_next = (part_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        c_d      = c_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    c_d     = sub;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1] ^ sub;
                end
            end
            ST_RUN: begin
                a_d    = a_q >> CHUNK;
                b_d    = b_q >> CHUNK;
                c_d    = slice_cout;
                part_d = part_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    result_d = part_next;
                    carry_d  = slice_cout;
                    ovf_d    = (a_msb_q == b_msb_q) && (part_next[WIDTH-1] != a_msb_q);
                    zero_d   = (part_next == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            c_q      <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            c_q      <= c_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed and randomised checks of addsub_seq at three WIDTH/CHUNK points.
module tb_addsub_seq;

    logic clk;
    logic rst;

    // main instance: WIDTH=32, CHUNK=8
    logic        start0, sub0;
    logic [31:0] a0, b0, res0;
    logic        busy0, done0, c0, v0, z0;

    // WIDTH=32, CHUNK=32
    logic        start1, sub1;
    logic [31:0] a1, b1, res1;
    logic        busy1, done1, c1, v1, z1;

    // WIDTH=16, CHUNK=4
    logic        start2, sub2;
    logic [15:0] a2, b2, res2;
    logic        busy2, done2, c2, v2, z2;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res = 32'h0;

    addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(res0), .carry(c0), .overflow(v0), .zero(z0)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .carry(c1), .overflow(v1), .zero(z1)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .carry(c2), .overflow(v2), .zero(z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-word reference: {zero, overflow, carry, result} for a w-bit op.
    function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        logic [63:0] m, full;
        logic [31:0] r;
        logic sa, sb, sr, v;
        m    = (64'h1 << w) - 64'h1;
        full = ({32'h0, a} & m) + ({32'h0, s ? ~b : b} & m) + {63'h0, s};
        r    = full[31:0] & m[31:0];
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = r[w-1];
        v    = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {(r == 32'h0), v, full[w], r};
    endfunction

    // Called #1 after an edge; returns #1 after the edge that enters DONE.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic ec, input logic ev,
                        input logic ez, input bit inject);
        start0 = 1'b1; a0 = a; b0 = b; sub0 = s;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("busy_run%0d", k), busy0, 1'b1);
            chk($sformatf("done_run%0d", k), done0, 1'b0);
            chk($sformatf("res_hold%0d", k), res0, last_res);
            if (inject && k == 1) begin
                start0 = 1'b1; a0 = 32'd5; b0 = 32'd5; sub0 = 1'b0;
            end
            if (inject && k == 2) start0 = 1'b0;
            tick();
        end
        chk("busy_done", busy0, 1'b0);
        chk("done_pulse", done0, 1'b1);
        chk("result", res0, er);
        chk("carry", c0, ec);
        chk("overflow", v0, ev);
        chk("zero", z0, ez);
        last_res = er;
    endtask

    initial begin
        logic [34:0] exp;
        int cyc;
        rst = 1'b1;
        start0 = 1'b1; sub0 = 1'b0; a0 = 32'd1; b0 = 32'd2;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
        tick();
        tick();
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_result", res0, 32'h0);
        chk("rst_carry", c0, 1'b0);
        chk("rst_ovf", v0, 1'b0);
        chk("rst_zero", z0, 1'b0);
        rst = 1'b0;
        start0 = 1'b0;
        tick();
        chk("post_rst_busy", busy0, 1'b0);

        op32(32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
        tick();
        chk("done_one_cycle", done0, 1'b0);
        op32(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 0);
        tick();
        op32(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_busy", busy0, 1'b0);
            chk("idle_done", done0, 1'b0);
            chk("idle_res", res0, 32'hFFFFFFFF);
        end

        // back-to-back: second start issued while done is high
        op32(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 0);
        op32(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0);
        tick();

        // abort with reset at the second RUN edge
        start0 = 1'b1; a0 = 32'd9; b0 = 32'd9; sub0 = 1'b0;
        tick();
        start0 = 1'b0;
        chk("abort_busy", busy0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy0", busy0, 1'b0);
        chk("abort_done0", done0, 1'b0);
        chk("abort_result", res0, 32'h0);
        chk("abort_flags", {29'h0, c0, v0, z0}, 32'h0);
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done0) cyc++;
            tick();
        end
        chk("abort_no_done", cyc, 0);
        last_res = 32'h0;

        op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0);
        tick();
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 0);
        tick();
        op32(32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
        tick();

        // N=1: directed then random
        start1 = 1'b1; a1 = 32'h12345678; b1 = 32'h11111111; sub1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_busy", busy1, 1'b1);
        tick();
        chk("n1_done_e2", done1, 1'b1);
        chk("n1_result", res1, 32'h01234567);
        chk("n1_carry", c1, 1'b1);
        tick();
        for (int i = 0; i < 1000; i++) begin
            start1 = 1'b1; a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom);
            if (i % 50 == 0) b1 = a1;
            exp = model(32, a1, b1, sub1);
            tick();
            start1 = 1'b0;
            cyc = 0;
            while (!done1 && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("n1_latency", cyc, 1);
            chk("n1_rnd_result", res1, exp[31:0]);
            chk("n1_rnd_carry", c1, exp[32]);
            chk("n1_rnd_ovf", v1, exp[33]);
            chk("n1_rnd_zero", z1, exp[34]);
            tick();
        end

        // WIDTH=16, CHUNK=4 random
        for (int i = 0; i < 1000; i++) begin
            start2 = 1'b1; a2 = 16'($urandom); b2 = 16'($urandom); sub2 = 1'($urandom);
            if (i % 50 == 0) b2 = a2;
            exp = model(16, {16'h0, a2}, {16'h0, b2}, sub2);
            tick();
            start2 = 1'b0;
            cyc = 0;
            while (!done2 && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("w16_latency", cyc, 4);
            chk("w16_rnd_result", {16'h0, res2}, exp[31:0]);
            chk("w16_rnd_carry", c2, exp[32]);
            chk("w16_rnd_ovf", v2, exp[33]);
            chk("w16_rnd_zero", z2, exp[34]);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised sequential adder/subtractor for the pipelined CPU's multi-cycle execute path. It generalises the subtract-mask scheme: operand B is XORed with a mode-derived all-ones/all-zeros mask and the carry-in is set by the mode. It processes WIDTH bits in CHUNK-bit slices, one slice per clock, LSB first, with a start/busy/done handshake. It also produces carry, signed-overflow and zero flags.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle. N = WIDTH/CHUNK. CHUNK = WIDTH gives N = 1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled at rising edge.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while an operation is in RUN.
- done  out  1  one-cycle pulse: result and flags just updated.
- result  out  WIDTH  last completed sum/difference.
- carry  out  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after N slice cycles.
  - DONE→RUN on start (back-to-back); otherwise DONE→IDLE.
  - start in RUN is ignored.
- On accept:
  - Latch a into the A shift register.
  - Latch b XOR {WIDTH{sub}} into the B shift register.
  - Set running carry = sub.
  - Clear the slice counter.
  - Latch the MSB of a and the MSB of the masked b.
- Each RUN cycle:
  - {c, s} = A[CHUNK-1:0] + B[CHUNK-1:0] + c.
  - s shifts into the MSB end of the partial-result register.
  - A and B shift right by CHUNK.
  - Counter increments.
- Entering DONE, load the output registers:
  - result = partial result.
  - carry = final c.
  - overflow = (latched a MSB == latched masked-b MSB) && (result MSB != a MSB).
  - zero = (result == 0).
- result and flags hold their values from DONE until the next DONE, including through the next RUN.
- busy = (state == RUN). done = (state == DONE).
- Arithmetic is modulo 2^WIDTH. No exceptions are raised; the flags are informational only.

## Timing
- Reset values: state IDLE; busy, done, result, carry, overflow and zero all 0. Counter and shift registers are 0.
- rst has priority over start in the same edge. Reset mid-RUN aborts the operation: no done pulse, outputs return to 0.
- Latency, with start sampled at edge E0:
  - busy is high from after E0 through edge EN.
  - done is high for exactly the cycle after EN and is sampled high at E(N+1).
  - Start-to-done is N+1 edges.
- Throughput: start asserted during the DONE cycle is accepted. Sustained issue is one operation per N+1 cycles.
- Holding start high continuously re-issues an operation at every DONE.

## Structure
- Shared package addsub_pkg:
  - State enum (IDLE, RUN, DONE).
  - Mode constants MODE_ADD = 1'b0, MODE_SUB = 1'b1.
  - Function computing N from WIDTH and CHUNK.
- Elaboration check: an error is raised if WIDTH % CHUNK != 0.
- One sub-module, addsub_chunk: a combinational CHUNK-bit adder with cin/cout.
- The top level holds the FSM, the counter of width $clog2(N+1), the shift registers, the mask and the flag logic.

## Test plan
All scenarios use WIDTH=32, CHUNK=8 (N=4) unless stated.
- Reset: assert rst for 2 cycles → busy=0, done=0, result=0, all flags 0. start held high during rst is not accepted.
- Add wrap: a=0x00000001, b=0xFFFFFFFF, sub=0 → at E5 done=1, result=0x00000000, carry=1, zero=1, overflow=0. busy is high for edges E1–E4 only.
- Sub overflow: a=0x80000000, b=0x00000001, sub=1 → result=0x7FFFFFFF, carry=1, overflow=1, zero=0.
- Sub borrow: a=0, b=1, sub=1 → result=0xFFFFFFFF, carry=0, overflow=0. Then pulse start mid-RUN with a=5, b=5 → ignored, and the outputs are unchanged after the next done.
- Back-to-back and abort:
  - Start in the DONE cycle with a=3, b=4, sub=0 → the next done comes 5 edges later with result=7.
  - A new op with rst asserted at the second RUN edge → no done pulse, all outputs 0.
- Parameter sweep: WIDTH=32 with CHUNK=32 (N=1, done at E2), and WIDTH=16 with CHUNK=4. Apply 1000 random operations in each, checking against a golden model for result, carry, overflow and zero.
